// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) definitions for the transmit encoder and the io_in decoder.
// Codeword bit k carries Hamming position k+1.
package hamming74_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_LO = 2'd1,
    ST_SEND_HI = 2'd2,
    ST_GAP     = 2'd3
  } tx_state_e;

  localparam logic [6:0] IDLE_WORD_DEFAULT = 7'b0000000;

  // Parity bit locations inside the codeword; the decoder builds its syndrome from these.
  localparam int P1_BIT = 0;
  localparam int P2_BIT = 1;
  localparam int P3_BIT = 3;

  function automatic logic [6:0] encode74(input logic [3:0] nibble);
    logic d1, d2, d3, d4;
    d1 = nibble[0];
    d2 = nibble[1];
    d3 = nibble[2];
    d4 = nibble[3];
    return {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock pointer FIFO; pointers carry one extra wrap bit to separate full from empty.
// Read data is the head entry, valid whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/hamming74_tx_encoder.sv
// Byte-to-Hamming(7,4) pad transmitter: bytes are queued, split low nibble first,
// and each codeword is held on io_out for HOLD_CYCLES, followed by GAP_CYCLES of IDLE_WORD.
module hamming74_tx_encoder
  import hamming74_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         HOLD_CYCLES = 4,
  parameter int         GAP_CYCLES  = 2,
  parameter logic [6:0] IDLE_WORD   = IDLE_WORD_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [6:0]  io_out,
  output logic [6:0]  io_oeb,
  output logic        sym_strobe,
  output logic        busy,
  output logic [15:0] tx_count,
  output logic [1:0]  debug_state
);

  // Handshake: a byte transfers on the rising edge where in_valid && in_ready;
  // in_ready is registered and reflects FIFO occupancy after that edge's push/pop.

  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  tx_state_e      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]     byte_q;
  logic           hold_last, gap_last;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_rd_data;
  logic [CW-1:0]  fifo_count, fifo_count_next;

  logic [6:0]     io_next;
  logic           strobe_next;

  assign fifo_push = in_valid && in_ready && !fifo_full;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .push     (fifo_push),
    .wr_data  (in_data),
    .pop      (fifo_pop),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign hold_last = (cnt == CNT_W'(HOLD_CYCLES - 1));
  assign gap_last  = (cnt == CNT_W'(GAP_LAST));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      byte_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (fifo_pop) byte_q <= fifo_rd_data;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (hold_last) begin
          cnt_next   = '0;
          state_next = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (hold_last) begin
          cnt_next = '0;
          // With no gap the next byte starts straight after the high codeword.
          if (GAP_CYCLES > 0) begin
            state_next = ST_GAP;
          end else if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = ST_SEND_LO;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          cnt_next = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = ST_SEND_LO;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    io_next     = IDLE_WORD;
    strobe_next = 1'b0;
    case (state)
      ST_SEND_LO: begin
        io_next     = encode74(byte_q[3:0]);
        strobe_next = (cnt == '0);
      end
      ST_SEND_HI: begin
        io_next     = encode74(byte_q[7:4]);
        strobe_next = (cnt == '0);
      end
      default: ;
    endcase
  end

  assign fifo_count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      io_out     <= IDLE_WORD;
      io_oeb     <= 7'h7F;
      sym_strobe <= 1'b0;
      in_ready   <= 1'b0;
      tx_count   <= '0;
    end else begin
      io_out     <= io_next;
      io_oeb     <= '0;
      sym_strobe <= strobe_next;
      in_ready   <= (fifo_count_next != CW'(FIFO_DEPTH));
      tx_count   <= tx_count + {15'd0, sym_strobe};
    end
  end

  assign busy        = (state != ST_IDLE) || !fifo_empty;
  assign debug_state = state;

endmodule
